isi_transmitter: RTL

- Drives a parallel ISI camera bus (vsync, hsync/HREF, 8-bit pixdata) from an upstream pixel stream, emulating an image sensor.
- It is the transmit end of the interface that the camera reader consumes. It is used for sensor-less bring-up, loopback verification and synthetic test frames.
- Frame geometry is fixed by parameters. Everything is synchronous to pixclk_i.

---
 rtl/isi_tx_pkg.sv | 33 +++
 rtl/isi_tx_pattern_gen.sv | 28 ++
 rtl/isi_transmitter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/isi_tx_pkg.sv
// Shared types and defaults for the ISI camera-bus transmitter.
package isi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP,
    ST_END
  } state_e;

  typedef enum logic [1:0] {
    PAT_STREAM,
    PAT_RAMP,
    PAT_BARS,
    PAT_CHECKER
  } pattern_e;

  localparam logic [7:0] FILL_DEFAULT = 8'h00;

  // Largest of four line counts, used to size the line counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/isi_tx_pattern_gen.sv
// Synthetic pixel byte generator for sensor-less bring-up.
// Only instantiated when ISI_TX_TEST_PATTERN_EN is defined.
module isi_tx_pattern_gen
  import isi_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned CW    = 10,
  parameter int unsigned LW    = 10
) (
  input  logic [CW-1:0] col,
  input  logic [LW-1:0] line,
  input  pattern_e      sel,
  output logic [7:0]    pattern_byte_c
);

  // Pattern byte from the current column/line position.
  always_comb begin
    pattern_byte_c = 8'h00;
    case (sel)
      PAT_RAMP:    pattern_byte_c = 8'(col);
      PAT_BARS:    pattern_byte_c = {3'((32'(col) * 32'd8) / 32'(WIDTH)), 5'b0};
      PAT_CHECKER: pattern_byte_c = ((((32'(col) >> 3) ^ (32'(line) >> 3)) & 32'd1) != 32'd0)
                                    ? 8'hFF : 8'h00;
      default:     pattern_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/isi_transmitter.sv
// ISI camera-bus transmitter: emulates an image sensor driving vsync/HREF/pixdata
// from an upstream byte stream. Optional test patterns under ISI_TX_TEST_PATTERN_EN.
module isi_transmitter
  import isi_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned HBLANK      = 16,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned VBP_LINES   = 4,
  parameter int unsigned VFP_LINES   = 2,
  parameter logic [7:0]  FILL        = FILL_DEFAULT
) (
  input  logic       pixclk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic [7:0] pixdata_i,
  input  logic       pixvalid_i,
  output logic       pixready_o,
  input  logic [1:0] pattern_sel_i,
  input  logic       clear_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [7:0] pixdata_o,
  output logic       frame_done_o,
  output logic       underrun_o,
  output logic       busy_o
);

  localparam int unsigned L     = WIDTH + HBLANK;
  localparam int unsigned MAXLN = max4(VSYNC_LINES, VBP_LINES, HEIGHT, VFP_LINES);
  localparam int unsigned CW    = $clog2(L);
  localparam int unsigned LW    = $clog2(MAXLN) + 1;

  state_e        state;
  state_e        after_state;
  logic [CW-1:0] col_cnt;
  logic [LW-1:0] line_cnt;
  int unsigned   state_lines;
  logic          pix_phase;
  logic          line_end;
  logic          last_line;
  logic          stream_sel;
  logic          underrun_set;
  logic [7:0]    pat_byte_c;
  logic [7:0]    pix_byte;

`ifdef ISI_TX_TEST_PATTERN_EN
  pattern_e sel;
  assign sel        = pattern_e'(pattern_sel_i);
  assign stream_sel = (sel == PAT_STREAM);

  isi_tx_pattern_gen #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .LW    (LW)
  ) u_pattern_gen (
    .col            (col_cnt),
    .line           (line_cnt),
    .sel            (sel),
    .pattern_byte_c (pat_byte_c)
  );
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel_i;
  assign stream_sel         = 1'b1;
  assign pat_byte_c         = 8'h00;
`endif

  // Position decode: pixel phase, end of line, last line of the current state.
  assign pix_phase    = (state == ST_ACTIVE) && (col_cnt < CW'(WIDTH));
  assign line_end     = (col_cnt == CW'(L - 1));
  assign last_line    = (line_cnt == LW'(state_lines - 32'd1));
  assign pixready_o   = pix_phase && stream_sel;
  assign underrun_set = pixready_o && !pixvalid_i;

  // Line count of the current timed state and the state that follows it.
  always_comb begin
    state_lines = 32'd1;
    after_state = ST_IDLE;
    case (state)
      ST_VSYNC: begin
        state_lines = VSYNC_LINES;
        after_state = (VBP_LINES == 0) ? ST_ACTIVE : ST_VBP;
      end
      ST_VBP: begin
        state_lines = VBP_LINES;
        after_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        state_lines = HEIGHT;
        after_state = (VFP_LINES == 0) ? ST_END : ST_VFP;
      end
      ST_VFP: begin
        state_lines = VFP_LINES;
        after_state = ST_END;
      end
      default: begin
        state_lines = 32'd1;
        after_state = ST_IDLE;
      end
    endcase
  end

  // Byte placed on the bus for the current position.
  always_comb begin
    pix_byte = 8'h00;
    if (pix_phase) begin
      if (stream_sel) pix_byte = pixvalid_i ? pixdata_i : FILL;
      else            pix_byte = pat_byte_c;
    end
  end

  // Frame sequencer with registered bus outputs.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      col_cnt      <= '0;
      line_cnt     <= '0;
      hsync_o      <= 1'b0;
      vsync_o      <= 1'b0;
      pixdata_o    <= 8'h00;
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      hsync_o      <= pix_phase;
      vsync_o      <= (state == ST_VSYNC);
      pixdata_o    <= pix_byte;
      frame_done_o <= 1'b0;

      if (underrun_set) underrun_o <= 1'b1;
      else if (clear_i) underrun_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          col_cnt  <= '0;
          line_cnt <= '0;
          if (enable_i) begin
            state  <= ST_VSYNC;
            busy_o <= 1'b1;
          end
        end
        ST_END: begin
          col_cnt  <= '0;
          line_cnt <= '0;
          state    <= enable_i ? ST_VSYNC : ST_IDLE;
          busy_o   <= enable_i;
        end
        default: begin
          if (line_end) begin
            col_cnt <= '0;
            if (last_line) begin
              line_cnt <= '0;
              state    <= after_state;
              if (after_state == ST_END) frame_done_o <= 1'b1;
            end else begin
              line_cnt <= line_cnt + LW'(1);
            end
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
